// File: rtl/fixed_div_seq_pkg.sv
// Shared fixed-point definitions for the divider and the add/mult/negator family.
// Default format is sign-magnitude Q15.16 in a 32-bit word.
package fixed_pkg;

    typedef enum logic [1:0] {IDLE, BUSY, FINISH, DONE} state_t;

    localparam int FIX_N = 32;
    localparam int FIX_Q = 16;

    localparam logic [FIX_N-1:0] FIX_ONE     = 32'h0001_0000;
    localparam logic [FIX_N-2:0] FIX_MAG_MAX = '1;

    // A zero magnitude always carries a positive sign.
    function automatic logic fix_norm_zero(input logic sign, input logic mag_is_zero);
        return sign & ~mag_is_zero;
    endfunction

endpackage

// File: rtl/fixed_div_seq_if.sv
// Operand/result handshake bundle for fixed_div_seq.
// master = producer/consumer side, slave = divider side.
interface fixed_div_seq_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic         in_ready;
    logic [N-1:0] a;
    logic [N-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [N-1:0] c;
    logic         div_by_zero;
    logic         overflow;
    logic         busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, div_by_zero, overflow, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, div_by_zero, overflow, busy
    );
endinterface

// File: rtl/fixed_div_seq_step.sv
// One restoring long-division step: shift in the next dividend bit, subtract if it fits.
module fixed_div_step #(
    parameter int W = 32
) (
    input  logic [W-1:0] rem_i,
    input  logic         bit_i,
    input  logic [W-2:0] divisor_i,
    output logic [W-1:0] rem_o,
    output logic         q_o
);
    logic [W:0] shifted;

    always_comb begin
        shifted = {rem_i, bit_i};
        q_o     = (shifted >= {2'b00, divisor_i});
        rem_o   = q_o ? W'(shifted - {2'b00, divisor_i}) : shifted[W-1:0];
    end
endmodule

// File: rtl/fixed_div_seq.sv
// Sequential sign-magnitude fixed-point divider, restoring division, one quotient bit per cycle.
// Define FIXED_DIV_ROUND_EN to round half away from zero instead of truncating.
//
// state  | meaning
// IDLE   | in_ready high, waiting for operands
// BUSY   | STEPS restoring iterations
// FINISH | saturate / round / sign-fix and register the result
// DONE   | out_valid high, hold result until out_ready
module fixed_div_seq
    import fixed_pkg::*;
#(
    parameter int N = 32,
    parameter int Q = 16
) (
    input  logic           clk,
    input  logic           reset,
    fixed_div_seq_if.slave bus
);
    localparam int STEPS = N - 1 + Q;
    localparam int CW    = $clog2(STEPS);

    state_t           state_q;
    logic             sign_q;
    logic             a_sign_q;
    logic             dbz_q;
    logic [STEPS-1:0] dividend_q;
    logic [STEPS-1:0] quot_q;
    logic [N-1:0]     rem_q;
    logic [N-2:0]     divisor_q;
    logic [CW-1:0]    count_q;
    logic             in_ready_q;
    logic             out_valid_q;
    logic             busy_q;
    logic             div_by_zero_q;
    logic             overflow_q;
    logic [N-1:0]     c_q;

    logic [N-1:0]     rem_d;
    logic             q_bit_d;
    logic [N-1:0]     mag_ext_d;
    logic             sat_d;
    logic [N-2:0]     mag_d;
    logic             sign_d;

    fixed_div_step #(.W(N)) u_step (
        .rem_i     (rem_q),
        .bit_i     (dividend_q[STEPS-1]),
        .divisor_i (divisor_q),
        .rem_o     (rem_d),
        .q_o       (q_bit_d)
    );

    // Extra top bit of mag_ext_d catches a rounding carry out of the magnitude.
    always_comb begin
`ifdef FIXED_DIV_ROUND_EN
        mag_ext_d = {1'b0, quot_q[N-2:0]}
                  + {{(N-1){1'b0}}, ({rem_q, 1'b0} >= {2'b00, divisor_q})};
`else
        mag_ext_d = {1'b0, quot_q[N-2:0]};
`endif
        sat_d  = (|quot_q[STEPS-1:N-1]) | mag_ext_d[N-1];
        mag_d  = sat_d ? {(N-1){1'b1}} : mag_ext_d[N-2:0];
        sign_d = fix_norm_zero(sign_q, mag_d == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            c_q           <= '0;
            div_by_zero_q <= 1'b0;
            overflow_q    <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (bus.in_valid && in_ready_q) begin
                        sign_q     <= bus.a[N-1] ^ bus.b[N-1];
                        a_sign_q   <= bus.a[N-1];
                        dividend_q <= {bus.a[N-2:0], {Q{1'b0}}};
                        divisor_q  <= bus.b[N-2:0];
                        rem_q      <= '0;
                        quot_q     <= '0;
                        count_q    <= CW'(STEPS - 1);
                        dbz_q      <= (bus.b[N-2:0] == '0);
                        in_ready_q <= 1'b0;
                        busy_q     <= 1'b1;
                        state_q    <= BUSY;
                    end
                end
                // Iterates even on divide-by-zero so latency never depends on data.
                BUSY: begin
                    rem_q      <= rem_d;
                    dividend_q <= {dividend_q[STEPS-2:0], 1'b0};
                    quot_q     <= {quot_q[STEPS-2:0], q_bit_d};
                    count_q    <= count_q - 1'b1;
                    if (count_q == '0) state_q <= FINISH;
                end
                FINISH: begin
                    c_q           <= dbz_q ? {a_sign_q, {(N-1){1'b1}}} : {sign_d, mag_d};
                    div_by_zero_q <= dbz_q;
                    overflow_q    <= ~dbz_q & sat_d;
                    out_valid_q   <= 1'b1;
                    busy_q        <= 1'b0;
                    state_q       <= DONE;
                end
                DONE: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready    = in_ready_q;
    assign bus.out_valid   = out_valid_q;
    assign bus.c           = c_q;
    assign bus.div_by_zero = div_by_zero_q;
    assign bus.overflow    = overflow_q;
    assign bus.busy        = busy_q;
endmodule

// File: tb/tb_fixed_div_seq.sv
// Self-checking bench for fixed_div_seq (N=32, Q=16) against an arithmetic reference model.
// Build with FIXED_DIV_ROUND_EN defined to check the rounding variant.
module tb_fixed_div_seq;
    import fixed_pkg::*;

    localparam int N     = 32;
    localparam int Q     = 16;
    localparam int STEPS = N - 1 + Q;
    localparam int LAT   = STEPS + 2;
    localparam int TPUT  = STEPS + 3;

`ifdef FIXED_DIV_ROUND_EN
    localparam logic [31:0] NEG_TWO_THIRDS = 32'h8000AAAB;
`else
    localparam logic [31:0] NEG_TWO_THIRDS = 32'h8000AAAA;
`endif

    localparam logic [31:0] DA [5] = '{32'h00060000, 32'h80020000, 32'h00050000, 32'h40000000, 32'h80000000};
    localparam logic [31:0] DB [5] = '{32'h00020000, 32'h00030000, 32'h80000000, 32'h00008000, FIX_ONE};
    localparam logic [31:0] DC [5] = '{32'h00030000, NEG_TWO_THIRDS, 32'h7FFFFFFF, 32'h7FFFFFFF, 32'h00000000};
    localparam logic        DZ [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam logic        DO [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};

    logic clk = 1'b0;
    logic reset;
    int   checks  = 0;
    int   errors  = 0;
    int   cyc     = 0;
    int   acc_cyc = 0;

    fixed_div_seq_if #(.N(N)) dif ();

    fixed_div_seq #(.N(N), .Q(Q)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (dif)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Exact quotient from integer division of the scaled magnitudes.
    function automatic void ref_div(input logic [31:0] av, input logic [31:0] bv,
                                    output logic [31:0] cv, output logic dz, output logic ov);
        longint unsigned am, bm, q, r, mag;
        logic s;
        am = longint'(av[30:0]);
        bm = longint'(bv[30:0]);
        s  = av[31] ^ bv[31];
        dz = 1'b0;
        ov = 1'b0;
        if (bm == 0) begin
            dz = 1'b1;
            cv = {av[31], FIX_MAG_MAX};
            return;
        end
        q   = (am << Q) / bm;
        r   = (am << Q) % bm;
        mag = q;
`ifdef FIXED_DIV_ROUND_EN
        if (2 * r >= bm) mag = mag + 1;
`else
        if (r > bm) mag = 0;
`endif
        if (mag > 64'h7FFFFFFF) begin
            ov  = 1'b1;
            mag = 64'h7FFFFFFF;
        end
        if (mag == 0) s = 1'b0;
        cv = {s, mag[30:0]};
    endfunction

    // Drives one operation; called and returns around a falling edge.
    task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input bit ack,
                         output logic [31:0] cv, output logic dz, output logic ov,
                         output int lat, output bit to);
        int n;
        to  = 1'b0;
        lat = 0;
        cv  = '0;
        dz  = 1'b0;
        ov  = 1'b0;
        n   = 0;
        while (!dif.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!dif.in_ready) begin
            to = 1'b1;
            return;
        end
        dif.a        = av;
        dif.b        = bv;
        dif.in_valid = 1'b1;
        @(posedge clk);
        #1 acc_cyc = cyc;
        @(negedge clk);
        dif.in_valid = 1'b0;
        dif.a        = $urandom;
        dif.b        = $urandom;
        n = 0;
        while (n < 200) begin
            @(posedge clk);
            #1 n++;
            if (dif.out_valid) break;
        end
        if (!dif.out_valid) begin
            to = 1'b1;
            @(negedge clk);
            return;
        end
        lat = n + 1;
        cv  = dif.c;
        dz  = dif.div_by_zero;
        ov  = dif.overflow;
        @(negedge clk);
        if (ack) begin
            dif.out_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            dif.out_ready = 1'b0;
        end
    endtask

    task automatic test_reset();
        reset         = 1'b1;
        dif.in_valid  = 1'b0;
        dif.out_ready = 1'b0;
        dif.a         = '0;
        dif.b         = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (dif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", dif.in_ready);
        end
        checks++;
        if (dif.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_out_valid got %b want 0", dif.out_valid);
        end
        checks++;
        if (dif.c !== 32'h0) begin
            errors++;
            $display("FAIL reset_c got %h want 00000000", dif.c);
        end
        checks++;
        if ({dif.div_by_zero, dif.overflow, dif.busy} !== 3'b000) begin
            errors++;
            $display("FAIL reset_flags got dbz=%b ovf=%b busy=%b want 000",
                     dif.div_by_zero, dif.overflow, dif.busy);
        end
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_directed();
        logic [31:0] cv;
        logic dz, ov;
        int lat;
        bit to;
        for (int i = 0; i < 5; i++) begin
            do_op(DA[i], DB[i], 1'b1, cv, dz, ov, lat, to);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL dir%0d_timeout no result within budget", i);
                continue;
            end
            checks++;
            if (cv !== DC[i]) begin
                errors++;
                $display("FAIL dir%0d_c a=%h b=%h got %h want %h", i, DA[i], DB[i], cv, DC[i]);
            end
            checks++;
            if ({dz, ov} !== {DZ[i], DO[i]}) begin
                errors++;
                $display("FAIL dir%0d_flags got dbz=%b ovf=%b want dbz=%b ovf=%b", i, dz, ov, DZ[i], DO[i]);
            end
            checks++;
            if (lat !== LAT) begin
                errors++;
                $display("FAIL dir%0d_latency got %0d want %0d", i, lat, LAT);
            end
            checks++;
            if ({dif.out_valid, dif.in_ready} !== 2'b01) begin
                errors++;
                $display("FAIL dir%0d_after_ack got out_valid=%b in_ready=%b want 0 1",
                         i, dif.out_valid, dif.in_ready);
            end
        end
    endtask

    task automatic test_hold();
        logic [31:0] cv, ec;
        logic dz, ov, edz, eov;
        int lat, bad;
        bit to;
        ref_div(32'h00070000, 32'h00020000, ec, edz, eov);
        do_op(32'h00070000, 32'h00020000, 1'b0, cv, dz, ov, lat, to);
        checks++;
        if (to) begin
            errors++;
            $display("FAIL hold_timeout no result within budget");
            return;
        end
        checks++;
        if ({cv, dz, ov} !== {ec, edz, eov}) begin
            errors++;
            $display("FAIL hold_result got %h %b %b want %h %b %b", cv, dz, ov, ec, edz, eov);
        end
        bad = 0;
        repeat (10) begin
            @(posedge clk);
            #1;
            if ({dif.c, dif.div_by_zero, dif.overflow, dif.out_valid, dif.in_ready}
                    !== {ec, edz, eov, 1'b1, 1'b0}) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL hold_stable got %0d unstable cycles want 0", bad);
        end
        @(negedge clk);
        dif.out_ready = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (dif.out_valid !== 1'b0) begin
            errors++;
            $display("FAIL release_out_valid got %b want 0", dif.out_valid);
        end
        checks++;
        if (dif.in_ready !== 1'b1) begin
            errors++;
            $display("FAIL release_in_ready got %b want 1", dif.in_ready);
        end
        @(negedge clk);
        dif.out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int seen;
        dif.a        = 32'h00060000;
        dif.b        = 32'h00020000;
        dif.in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        dif.in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #1;
        checks++;
        if (dif.busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_busy_before got %b want 1", dif.busy);
        end
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({dif.in_ready, dif.out_valid, dif.c, dif.busy} !== {1'b1, 1'b0, 32'h0, 1'b0}) begin
            errors++;
            $display("FAIL midreset_state got in_ready=%b out_valid=%b c=%h busy=%b want 1 0 00000000 0",
                     dif.in_ready, dif.out_valid, dif.c, dif.busy);
        end
        @(negedge clk);
        reset         = 1'b0;
        dif.out_ready = 1'b1;
        seen = 0;
        repeat (80) begin
            @(posedge clk);
            #1;
            if (dif.out_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin
            errors++;
            $display("FAIL midreset_stale got %0d out_valid cycles want 0", seen);
        end
        @(negedge clk);
        dif.out_ready = 1'b0;
    endtask

    task automatic test_random();
        logic [31:0] av, bv, cv, ec;
        logic dz, ov, edz, eov;
        int lat;
        bit to;
        for (int i = 0; i < 20; i++) begin
            av = $urandom;
            av[30:0] = av[30:0] >> $urandom_range(0, 30);
            bv = $urandom;
            bv[30:0] = bv[30:0] >> $urandom_range(0, 30);
            if ($urandom_range(0, 9) == 0) bv[30:0] = '0;
            ref_div(av, bv, ec, edz, eov);
            do_op(av, bv, 1'b1, cv, dz, ov, lat, to);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL rnd%0d_timeout no result within budget", i);
                continue;
            end
            checks++;
            if ({cv, dz, ov} !== {ec, edz, eov}) begin
                errors++;
                $display("FAIL rnd%0d_result a=%h b=%h got %h dbz=%b ovf=%b want %h dbz=%b ovf=%b",
                         i, av, bv, cv, dz, ov, ec, edz, eov);
            end
            checks++;
            if (lat !== LAT) begin
                errors++;
                $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, LAT);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [31:0] av, bv, cv, ec;
        logic dz, ov, edz, eov;
        int lat, prev;
        bit to;
        prev = -1;
        for (int i = 0; i < 4; i++) begin
            av = $urandom;
            av[30:0] = av[30:0] >> $urandom_range(8, 20);
            bv = $urandom;
            bv[30:0] = bv[30:0] >> $urandom_range(8, 20);
            ref_div(av, bv, ec, edz, eov);
            do_op(av, bv, 1'b1, cv, dz, ov, lat, to);
            checks++;
            if (to) begin
                errors++;
                $display("FAIL b2b%0d_timeout no result within budget", i);
                prev = -1;
                continue;
            end
            checks++;
            if ({cv, dz, ov} !== {ec, edz, eov}) begin
                errors++;
                $display("FAIL b2b%0d_result a=%h b=%h got %h want %h", i, av, bv, cv, ec);
            end
            if (prev >= 0) begin
                checks++;
                if (acc_cyc - prev !== TPUT) begin
                    errors++;
                    $display("FAIL b2b%0d_throughput got %0d cycles want %0d", i, acc_cyc - prev, TPUT);
                end
            end
            prev = acc_cyc;
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_hold();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
